// File: rtl/onchip_ram_arb.sv
// Two-master arbiter and sequencer for the on-chip SRAM bank.
// Round-robin between the CPU port (0) and DMA port (1). All SRAM-side signals are registered.
// The granted master gets a one-cycle ready pulse two cycles after arbitration.
module onchip_ram_arb #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_valid_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
    output logic                    m0_ready_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_valid_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
    output logic                    m1_ready_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

    output logic                    busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_WIDTH/8-1:0] ram_wstrb_q, ram_wstrb_d;
    logic                    m0_ready_q, m0_ready_d;
    logic                    m1_ready_q, m1_ready_d;
    logic                    busy_q, busy_d;

    logic req0, req1, any_req, arb_win;

    // Arbitration: in RESP the port being acked is masked, since its valid is the served request.
    always_comb begin
        req0 = m0_valid_i;
        req1 = m1_valid_i;
        if (state_q == StResp) begin
            if (grant_q) begin
                req1 = 1'b0;
            end else begin
                req0 = 1'b0;
            end
        end
        any_req = req0 | req1;
        // On a tie the port that was not served last wins; otherwise the lone requester wins.
        arb_win = (req0 && req1) ? ~last_grant_q : req1;
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_wstrb_d  = '0;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                state_d    = StResp;
                m0_ready_d = ~grant_q;
                m1_ready_d = grant_q;
            end
            StResp: begin
                last_grant_d = grant_q;
                state_d      = any_req ? StAccess : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Latch the winner's request whenever we enter ACCESS.
        if (state_d == StAccess && state_q != StAccess) begin
            grant_d     = arb_win;
            ram_addr_d  = arb_win ? m1_addr_i : m0_addr_i;
            ram_wdata_d = arb_win ? m1_wdata_i : m0_wdata_i;
            ram_wstrb_d = arb_win ? m1_wstrb_i : m0_wstrb_i;
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wstrb_q  <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wstrb_q  <= ram_wstrb_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Read data is forwarded only alongside the ready pulse.
    always_comb begin
        m0_ready_o  = m0_ready_q;
        m1_ready_o  = m1_ready_q;
        m0_rdata_o  = m0_ready_q ? ram_rdata_i : '0;
        m1_rdata_o  = m1_ready_q ? ram_rdata_i : '0;
        ram_addr_o  = ram_addr_q;
        ram_wdata_o = ram_wdata_q;
        ram_wstrb_o = ram_wstrb_q;
        busy_o      = busy_q;
    end

endmodule

// File: tb/tb_onchip_ram_arb.sv
// Self-checking bench for onchip_ram_arb: directed scenarios plus randomized two-master traffic,
// compared against a transaction-level model of the arbitration rules and a reference memory.
module tb_onchip_ram_arb;

    logic        clk;
    logic        rst;
    logic        mv [2];
    logic [14:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    onchip_ram_arb #(
        .ADDR_WIDTH(15),
        .DATA_WIDTH(32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_valid_i (mv[0]),
        .m0_addr_i  (ma[0]),
        .m0_wdata_i (mw[0]),
        .m0_wstrb_i (ms[0]),
        .m0_ready_o (m0_ready),
        .m0_rdata_o (m0_rdata),
        .m1_valid_i (mv[1]),
        .m1_addr_i  (ma[1]),
        .m1_wdata_i (mw[1]),
        .m1_wstrb_i (ms[1]),
        .m1_ready_o (m1_ready),
        .m1_rdata_o (m1_rdata),
        .ram_addr_o (ram_addr),
        .ram_wdata_o(ram_wdata),
        .ram_wstrb_o(ram_wstrb),
        .ram_rdata_i(ram_rdata),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: synchronous read, byte-masked write.
    logic [31:0] sram [0:32767];
    always @(posedge clk) begin
        ram_rdata <= sram[ram_addr];
        for (int b = 0; b < 4; b++) begin
            if (ram_wstrb[b]) sram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: at most one access in flight; age 0 = SRAM sampling cycle, age 1 = ack cycle.
    bit          inflight = 0;
    int          age = 0;
    int          inf_port = 0;
    int          last = 1;
    logic [14:0] inf_addr;
    logic [31:0] inf_wdata;
    logic [3:0]  inf_strb;
    logic [31:0] model_mem [int];
    bit          done [2];
    bit          granted [2];
    int          acks = 0;

    always @(negedge clk) begin
        bit e0, e1, v0, v1, acking;
        int win;
        logic [31:0] tmp;
        acking = inflight && age == 1;
        e0 = acking && inf_port == 0;
        e1 = acking && inf_port == 1;
        check_eq("ready0", m0_ready, e0);
        check_eq("ready1", m1_ready, e1);
        check_eq("busy", busy, inflight);
        check_eq("wstrb", ram_wstrb, (inflight && age == 0) ? inf_strb : 4'h0);
        if (inflight && age == 0) begin
            check_eq("ram_addr", ram_addr, inf_addr);
            check_eq("ram_wdata", ram_wdata, inf_wdata);
        end
        if (!e0) check_eq("rdata0_gated", m0_rdata, 0);
        if (!e1) check_eq("rdata1_gated", m1_rdata, 0);
        if (acking) begin
            acks++;
            done[inf_port] = 1;
            if (inf_strb == 4'h0) begin
                if (model_mem.exists(int'(inf_addr)))
                    check_eq("rdata", inf_port == 1 ? m1_rdata : m0_rdata,
                             model_mem[int'(inf_addr)]);
            end else if (model_mem.exists(int'(inf_addr))) begin
                tmp = model_mem[int'(inf_addr)];
                for (int b = 0; b < 4; b++) if (inf_strb[b]) tmp[b*8 +: 8] = inf_wdata[b*8 +: 8];
                model_mem[int'(inf_addr)] = tmp;
            end else if (inf_strb == 4'hF) begin
                model_mem[int'(inf_addr)] = inf_wdata;
            end
        end
        if (rst) begin
            // A write in its SRAM cycle still lands, but its content is now untracked.
            if (inflight && age == 0 && inf_strb != 0) model_mem.delete(int'(inf_addr));
            inflight = 0;
            last = 1;
        end else begin
            v0 = mv[0] && !e0;
            v1 = mv[1] && !e1;
            if (acking) last = inf_port;
            if ((!inflight || acking) && (v0 || v1)) begin
                win = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
                inflight = 1;
                age = 0;
                inf_port = win;
                inf_addr = ma[win];
                inf_wdata = mw[win];
                inf_strb = ms[win];
                granted[win] = 1;
            end else if (inflight && age == 0) begin
                age = 1;
            end else begin
                inflight = 0;
            end
        end
    end

    function automatic bit rdy(input int p);
        return (p == 1) ? m1_ready : m0_ready;
    endfunction

    // Issue one request on port p from an idle bus, wait (bounded) for its ready.
    task automatic do_req(input int p, input logic [14:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int lat);
        mv[p] = 1; ma[p] = a; mw[p] = d; ms[p] = s;
        lat = -1; rd = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy(p)) begin
                lat = i;
                rd = (p == 1) ? m1_rdata : m0_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        mv[p] = 0;
        if (lat < 0) check_eq("req_timeout", 1, 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [14:0] rand_addr();
        int r;
        r = $urandom_range(0, 17);
        if (r < 16) return 15'(r);
        if (r == 16) return 15'h7FFF;
        return 15'h0400;
    endfunction

    logic [31:0] rd;
    int lat, prev, prev_t, n, cur, cnt;
    bit pend [2];

    initial begin
        rst = 1;
        for (int p = 0; p < 2; p++) begin
            mv[p] = 1; ma[p] = 15'(32 + p); mw[p] = 0; ms[p] = 0;
        end

        // Reset held with both masters requesting.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ready0", m0_ready, 0);
            check_eq("rst_ready1", m1_ready, 0);
            check_eq("rst_wstrb", ram_wstrb, 0);
        end
        check_eq("rst_addr", ram_addr, 0);
        check_eq("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 0;
        cur = -1; lat = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin cur = m1_ready ? 1 : 0; lat = i; break; end
        end
        check_eq("first_grant_port", cur, 0);
        check_eq("first_grant_lat", lat, 2);
        @(posedge clk); #1;
        mv[0] = 0; mv[1] = 0;
        idle_cycles(4);

        // Single write then read.
        do_req(0, 15'h0400, 32'hDEADBEEF, 4'hF, rd, lat);
        check_eq("wr_lat", lat, 2);
        idle_cycles(1);
        do_req(0, 15'h0400, 32'h0, 4'h0, rd, lat);
        check_eq("rd_lat", lat, 2);
        check_eq("rd_data", rd, 32'hDEADBEEF);

        // Byte-masked write.
        do_req(0, 15'h1234, 32'h11223344, 4'hF, rd, lat);
        do_req(1, 15'h1234, 32'hAABBCCDD, 4'h5, rd, lat);
        check_eq("bm_wr_lat", lat, 2);
        do_req(0, 15'h1234, 32'h0, 4'h0, rd, lat);
        check_eq("bm_rd_data", rd, 32'h11BB33DD);
        idle_cycles(2);

        // Continuous contention: grants alternate, one ack every 2 cycles.
        mv[0] = 1; ma[0] = 15'h0010; ms[0] = 0;
        mv[1] = 1; ma[1] = 15'h7FFF; ms[1] = 0;
        prev = -1; prev_t = -1; n = 0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                cur = m1_ready ? 1 : 0;
                if (prev >= 0) begin
                    check_eq("cont_alternate", cur != prev, 1);
                    check_eq("cont_gap", t - prev_t, 2);
                end
                prev = cur; prev_t = t; n++;
            end
        end
        check_eq("cont_count", n, 7);
        @(posedge clk); #1;
        mv[0] = 0; mv[1] = 0;
        idle_cycles(4);

        // Reset during ACCESS of a port-1 write.
        mv[1] = 1; ma[1] = 15'h5555; mw[1] = 32'hCAFEF00D; ms[1] = 4'hF;
        @(posedge clk); #1;
        rst = 1;
        mv[0] = 1; ma[0] = 15'h0021; ms[0] = 0;
        ma[1] = 15'h0022; ms[1] = 0;
        @(negedge clk);
        check_eq("mid_busy_access", busy, 1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_eq("mid_no_ready1", m1_ready, 0);
        check_eq("mid_busy_cleared", busy, 0);
        cur = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin cur = m1_ready ? 1 : 0; break; end
        end
        check_eq("mid_restart_port", cur, 0);
        @(posedge clk); #1;
        mv[0] = 0; mv[1] = 0;
        idle_cycles(4);

        // Abandoned request still gets exactly one ready; port 1 then served without delay.
        mv[0] = 1; ma[0] = 15'h0400; ms[0] = 0;
        @(posedge clk); #1;
        mv[0] = 0;
        ma[0] = 15'h0001;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (m0_ready) cnt++;
        end
        check_eq("abandon_pulses", cnt, 1);
        @(posedge clk); #1;
        do_req(1, 15'h0007, 32'h0, 4'h0, rd, lat);
        check_eq("abandon_next_lat", lat, 2);
        idle_cycles(2);

        // Randomized traffic with post-grant scrambling, abandonment and occasional reset.
        for (int p = 0; p < 2; p++) begin
            done[p] = 0; granted[p] = 0; pend[p] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) begin
                if (rst) begin
                    mv[p] = 0; pend[p] = 0; done[p] = 0; granted[p] = 0;
                end else begin
                    if (done[p]) begin
                        mv[p] = 0; pend[p] = 0; done[p] = 0;
                    end
                    if (!pend[p]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            mv[p] = 1;
                            ma[p] = rand_addr();
                            mw[p] = $urandom;
                            ms[p] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
                            pend[p] = 1;
                            granted[p] = 0;
                        end
                    end else if (granted[p] && mv[p]) begin
                        case ($urandom_range(0, 7))
                            0: mv[p] = 0;
                            1, 2: begin
                                ma[p] = rand_addr();
                                mw[p] = $urandom;
                                ms[p] = 4'($urandom);
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
        @(posedge clk); #1;
        rst = 0;
        mv[0] = 0; mv[1] = 0;
        idle_cycles(6);
        check_eq("random_activity", acks > 500, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onchip_ram_arb.md
Name: onchip_ram_arb

Overview:
- Two-master arbiter and sequencer for the 128KB on-chip SRAM macro bank (32 x 1024x32 blocks, 15-bit word address, synchronous read, byte-masked write).
- Port 0 is the CPU data/instruction bus; port 1 is the DMA/peripheral bus.
- Shares the single SRAM port with round-robin fairness and registers all SRAM-side signals.
- Returns the response to the granted master with a one-cycle ready pulse.

Parameters:
- ADDR_WIDTH, 15, word-address width driven to the SRAM.
- DATA_WIDTH, 32, data width; byte-strobe width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous and active-high.
- m0_valid_i  in  1  port 0 request; held until m0_ready_o.
- m0_addr_i  in  ADDR_WIDTH  port 0 word address.
- m0_wdata_i  in  DATA_WIDTH  port 0 write data.
- m0_wstrb_i  in  DATA_WIDTH/8  port 0 byte strobes; 0 means read.
- m0_ready_o  out  1  one-cycle completion pulse for port 0.
- m0_rdata_o  out  DATA_WIDTH  port 0 read data, valid with m0_ready_o.
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_ready_o, m1_rdata_o: same as port 0, for port 1.
- ram_addr_o  out  ADDR_WIDTH  registered SRAM address.
- ram_wdata_o  out  DATA_WIDTH  registered SRAM write data.
- ram_wstrb_o  out  DATA_WIDTH/8  registered SRAM byte strobes; nonzero only in ACCESS.
- ram_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after the address is sampled.
- busy_o  out  1  high in ACCESS and RESP.

Behaviour:
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie).
  - All ready_o = 0, ram_addr_o = 0, ram_wdata_o = 0, ram_wstrb_o = 0, busy_o = 0.
- States:
  - IDLE: if any valid_i, select a winner and latch its addr/wdata/wstrb into the ram_* registers; set grant; go to ACCESS. Otherwise stay, with ram_wstrb_o = 0.
  - ACCESS: the SRAM samples ram_* at this cycle's clock edge. Go to RESP. Clear ram_wstrb_o at the transition.
  - RESP: pulse ready_o of the granted port for exactly one cycle. Set last_grant = grant.
    - If any valid_i is high, excluding the port being acked this cycle, arbitrate and go straight to ACCESS.
    - Otherwise go to IDLE.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the port not equal to last_grant wins.
- Latency: request seen in IDLE at cycle T → ACCESS at T+1 → ready_o at T+2.
  - Back-to-back throughput: one access per 2 cycles.
- Read data:
  - mN_rdata_o = ram_rdata_i when mN_ready_o = 1, else 0.
  - Writes also return the (don't-care) SRAM output with ready_o.
- Request stability:
  - Master signals are sampled only at arbitration.
  - Changes after grant have no effect on the access in flight.
  - A master deasserting valid before ready_o still receives the ready pulse.
- Write protection: ram_wstrb_o is never nonzero outside ACCESS; no spurious writes in IDLE or RESP.
- Simultaneous events:
  - The port acked in RESP may reassert valid in the next cycle.
  - Its valid in the RESP cycle itself is treated as its already-served request and ignored.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - The pending access is dropped with no ready_o pulse.
  - ram_wstrb_o = 0 and last_grant = 1.
- Invariants:
  - At most one ready_o is high per cycle.
  - ready_o is only ever high in RESP.

Test Plan:
- Reset: hold rst_i 3 cycles while both valid_i = 1 → no ready_o pulses, ram_wstrb_o = 0. After release, port 0 is granted first.
- Single write then read: port 0 writes addr 0x0400, wdata 0xDEADBEEF, wstrb 0xF, so m0_ready_o rises 2 cycles after valid. Then port 0 reads 0x0400 → m0_rdata_o = 0xDEADBEEF with ready.
- Contention: both ports hold valid continuously (m0 reads 0x0010, m1 reads 0x7FFF) → grants alternate 0,1,0,1 with ready pulses every 2 cycles. No port is served twice in a row.
- Byte mask: pre-load 0x11223344 at 0x1234, then port 1 writes 0xAABBCCDD with wstrb 0x5 → a subsequent read returns 0x11BB33DD.
- Reset mid-access: assert rst_i during ACCESS of a port-1 write → no m1_ready_o, busy_o = 0 the next cycle, arbitration restarts with port 0 priority.
- Abandoned request: port 0 drops valid the cycle after grant → m0_ready_o still pulses exactly once. The next port-1 request is served without delay.
